// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the AXI-Stream frame arbiter.
// Holds the FSM state encoding, source-index width helper and round-robin pick.
package axis_frame_pkg;

    localparam int MAX_SRC = 8;
    localparam int MAX_IDW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PAD    = 2'd2
    } state_t;

    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester strictly after 'last', wrapping modulo n; returns 'last' if none.
    function automatic logic [MAX_IDW-1:0] rr_next(input logic [MAX_SRC-1:0] req,
                                                   input logic [MAX_IDW-1:0] last,
                                                   input int n);
        logic [MAX_IDW-1:0] g;
        int idx;
        g = last;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(last) + k) % n;
            if (req[idx[MAX_IDW-1:0]]) g = idx[MAX_IDW-1:0];
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: next requester after last_grant.
module rr_arbiter
    import axis_frame_pkg::*;
#(
    parameter  int N_SRC = 2,
    localparam int IDW   = calc_idw(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDW-1:0]   last_grant_i,
    output logic [IDW-1:0]   grant_o,
    output logic             any_req_o
);

    assign any_req_o = |req_i;
    assign grant_o   = IDW'(rr_next(MAX_SRC'(req_i), MAX_IDW'(last_grant_i), N_SRC));

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin arbiter muxing N_SRC AXI-Stream sources onto one DMA port.
// Optional AXIS_FRAME_TIMEOUT_EN closes a stalled frame with a zero pad beat.
module axis_frame_arbiter
    import axis_frame_pkg::*;
#(
    parameter  int N_SRC      = 2,
    parameter  int DATA_WIDTH = 32,
    parameter  int FRAME_LEN  = 16,
    parameter  int TIMEOUT    = 256,
    localparam int IDW        = calc_idw(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SRC-1:0]            s_axis_tvalid,
    input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    output logic [N_SRC-1:0]            s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [IDW-1:0]              m_axis_tid,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic                        trunc_flag
);

    localparam int BCW = $clog2(FRAME_LEN + 1);

    state_t                              state_q, state_d;
    logic [IDW-1:0]                      grant_q, grant_d;
    logic [IDW-1:0]                      last_grant_q, last_grant_d;
    logic [BCW-1:0]                      beat_cnt_q, beat_cnt_d;
    logic [N_SRC-1:0][DATA_WIDTH-1:0]    src_data;
    logic [IDW-1:0]                      arb_grant;
    logic                                any_req;
    logic                                beat_last;

    assign src_data  = s_axis_tdata;
    assign beat_last = (beat_cnt_q == BCW'(FRAME_LEN - 1));
    assign busy      = (state_q != IDLE);

    rr_arbiter #(.N_SRC(N_SRC)) u_rr (
        .req_i        (s_axis_tvalid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .any_req_o    (any_req)
    );

`ifdef AXIS_FRAME_TIMEOUT_EN
    localparam int ICW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           trunc_q, trunc_d;

    assign trunc_flag = trunc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            trunc_q    <= trunc_d;
        end
    end
`else
    wire unused_timeout = (TIMEOUT > 0);
    assign trunc_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(N_SRC - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tid    = '0;
`ifdef AXIS_FRAME_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
        trunc_d       = trunc_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = arb_grant;
                    beat_cnt_d = '0;
                    state_d    = STREAM;
`ifdef AXIS_FRAME_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            STREAM: begin
                // Pure pass-through; grant is frozen until the tlast handshake.
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tdata           = src_data[grant_q];
                m_axis_tid             = grant_q;
                m_axis_tlast           = beat_last;
                s_axis_tready[grant_q] = m_axis_tready;
                if (s_axis_tvalid[grant_q] && m_axis_tready) begin
                    if (beat_last) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
`ifdef AXIS_FRAME_TIMEOUT_EN
                // Only a silent source ages the frame; DMA back-pressure does not.
                if (s_axis_tvalid[grant_q]) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == ICW'(TIMEOUT - 1)) begin
                    idle_cnt_d = '0;
                    state_d    = PAD;
                end else begin
                    idle_cnt_d = idle_cnt_q + ICW'(1);
                end
`endif
            end
`ifdef AXIS_FRAME_TIMEOUT_EN
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tid    = grant_q;
                if (m_axis_tready) begin
                    trunc_d      = 1'b1;
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                    state_d      = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter (N_SRC=2, FRAME_LEN=4, TIMEOUT=8).
// Directed table, multi-cycle sequences and random traffic against a frame-level model.
module tb_axis_frame_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int FL = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N-1:0]    s_axis_tready;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;
    logic [0:0]      m_axis_tid;
    logic            m_axis_tready = 1'b0;
    logic            busy;
    logic            trunc_flag;

    axis_frame_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .trunc_flag    (trunc_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, busy, s_axis_tready, trunc_flag});
    endfunction

    // Frame-level reference: owner = granted source (-1 between frames), left = beats remaining.
    int owner, left, prev;
    int seq [N];
    logic [N-1:0] mv;

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(((i + 1) << 12) + seq[i]);
    endfunction

    task automatic drive();
        s_axis_tvalid = mv;
        for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = data_of(i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("reset_outputs", dut_vec(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        owner = -1; prev = N - 1; mv = '0;
    endtask

    task automatic model_step(input string nm, output bit hs, output int hsrc, output bit hlast);
        logic ev, el, eid, eb;
        logic [DW-1:0] ed;
        logic [N-1:0] esr;
        hs = 0; hsrc = -1; hlast = 0;
        @(negedge clk);
        ev = 0; ed = '0; el = 0; eid = 0; eb = 0; esr = '0;
        if (owner >= 0) begin
            ev  = s_axis_tvalid[owner];
            ed  = s_axis_tdata[owner*DW +: DW];
            el  = (left == 1);
            eid = owner[0];
            eb  = 1'b1;
            esr = m_axis_tready ? N'(1 << owner) : '0;
        end
        check(nm, dut_vec(), 64'({ev, ed, el, eid, eb, esr, 1'b0}));
        if (owner < 0) begin
            if (|s_axis_tvalid) begin
                for (int k = N; k >= 1; k--)
                    if (s_axis_tvalid[(prev + k) % N]) owner = (prev + k) % N;
                left = FL;
            end
        end else if (ev && m_axis_tready) begin
            hs = 1; hsrc = owner; hlast = el;
            seq[owner]++;
            mv[owner] = 1'b0;
            left--;
            if (left == 0) begin
                prev = owner;
                owner = -1;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  sv;
        logic [31:0] d0;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic        eid;
        logic        eb;
        logic [1:0]  esr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        bit hs, hl;
        int hsrc, beats, lasts;
        bit done;
        int tids [$];
        int off [N];

        foreach (seq[i]) seq[i] = 0;
        // src0 alone streams 0x10..0x17: two frames with one arbitration cycle between.
        tbl[0]  = '{2'b01, 32'h10, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[1]  = '{2'b01, 32'h10, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[2]  = '{2'b01, 32'h11, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[3]  = '{2'b01, 32'h12, 1'b1, 1'b1, 32'h12, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[4]  = '{2'b01, 32'h13, 1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[5]  = '{2'b01, 32'h14, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[6]  = '{2'b01, 32'h14, 1'b1, 1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[7]  = '{2'b01, 32'h15, 1'b1, 1'b1, 32'h15, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[8]  = '{2'b01, 32'h16, 1'b1, 1'b1, 32'h16, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[9]  = '{2'b01, 32'h17, 1'b1, 1'b1, 32'h17, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[10] = '{2'b00, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 2'b00};

        do_reset();
        for (int r = 0; r < 11; r++) begin
            s_axis_tvalid = tbl[r].sv;
            s_axis_tdata  = {32'hDEAD_BEEF, tbl[r].d0};
            m_axis_tready = tbl[r].rdy;
            @(negedge clk);
            check($sformatf("tbl_row%0d", r), dut_vec(),
                  64'({tbl[r].ev, tbl[r].ed, tbl[r].el, tbl[r].eid, tbl[r].eb, tbl[r].esr, 1'b0}));
            @(posedge clk); #1;
        end

        // Both sources saturated: frames must alternate 0,1,0,1.
        do_reset();
        for (int c = 0; c < 40 && tids.size() < 4; c++) begin
            mv = 2'b11; drive(); m_axis_tready = 1'b1;
            model_step("alt", hs, hsrc, hl);
            if (hs && hl) tids.push_back(hsrc);
        end
        check("alt_frames", 64'(tids.size()), 64'd4);
        for (int k = 0; k < tids.size(); k++)
            check($sformatf("alt_tid%0d", k), 64'(tids[k]), 64'(k % 2));

        // DMA ready toggling mid-frame.
        do_reset();
        beats = 0; lasts = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            mv = 2'b01; drive();
            m_axis_tready = (c < 2) ? 1'b1 : c[0];
            model_step("stall", hs, hsrc, hl);
            if (hs) begin
                beats++;
                if (hl) begin lasts++; done = 1; end
            end
        end
        check("stall_done", 64'(done), 64'd1);
        check("stall_beats", 64'(beats), 64'(FL));
        check("stall_tlast", 64'(lasts), 64'd1);

        // Reset after two beats of a src1 frame, then src0 must win with a full frame.
        do_reset();
        beats = 0;
        for (int c = 0; c < 10 && beats < 2; c++) begin
            mv = 2'b10; drive(); m_axis_tready = 1'b1;
            model_step("pre_rst", hs, hsrc, hl);
            if (hs) beats++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", dut_vec(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        owner = -1; prev = N - 1; mv = '0;
        beats = 0; done = 0; hsrc = -1;
        begin
            int first_src;
            first_src = -1;
            for (int c = 0; c < 20 && !done; c++) begin
                mv = 2'b11; drive(); m_axis_tready = 1'b1;
                model_step("post_rst", hs, hsrc, hl);
                if (hs) begin
                    if (first_src < 0) first_src = hsrc;
                    beats++;
                    if (hl) done = 1;
                end
            end
            check("post_rst_src", 64'(first_src), 64'd0);
            check("post_rst_beats", 64'(beats), 64'(FL));
        end

        // Random traffic; sources never go silent long enough to hit the timeout.
        do_reset();
        foreach (off[i]) off[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i]) begin
                    off[i]++;
                    if (off[i] >= 4 || $urandom_range(0, 9) < 6) begin
                        mv[i] = 1'b1;
                        off[i] = 0;
                    end
                end
            end
            drive();
            m_axis_tready = ($urandom_range(0, 3) != 0);
            model_step("rand", hs, hsrc, hl);
        end

        // src1 sends two beats then goes silent.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            mv = 2'b10; drive(); m_axis_tready = 1'b1;
            model_step("to_pre", hs, hsrc, hl);
        end
        mv = 2'b00; drive();
`ifdef AXIS_FRAME_TIMEOUT_EN
        for (int c = 0; c < TO; c++) model_step("to_wait", hs, hsrc, hl);
        @(negedge clk);
        check("pad_beat", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid, s_axis_tready}),
              64'({1'b1, 32'h0, 1'b1, 1'b1, 2'b00}));
        @(posedge clk); #1;
        @(negedge clk);
        check("trunc_idle", 64'({trunc_flag, busy, m_axis_tvalid}), 64'({1'b1, 1'b0, 1'b0}));
        s_axis_tvalid = 2'b01;
        @(posedge clk); #1;
        @(negedge clk);
        check("resume", 64'({m_axis_tvalid, m_axis_tid, busy, trunc_flag}), 64'({1'b1, 1'b0, 1'b1, 1'b1}));
`else
        for (int c = 0; c < 20; c++) model_step("stuck", hs, hsrc, hl);
        @(negedge clk);
        check("stuck_state", 64'({busy, m_axis_tvalid, m_axis_tid, trunc_flag}), 64'({1'b1, 1'b0, 1'b1, 1'b0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
